vc_allocator: RTL and testbench
===============================

Name: vc_allocator

Overview:
- Virtual-channel allocator for a 5-port NoC router.
- Each upstream input VC needing a downstream VC names its output port. The block assigns at most one free downstream VC on that port per upstream VC and at most one upstream VC per downstream VC.
- Uses a separable input-first allocator with round-robin arbiters at both stages.
- Tracks downstream VC availability internally; it sits between the input buffers/route computation and the switch allocator.

Parameters:
- VC_TOTAL, 10, total VCs in the router = PORT_NUM*VC_NUM; indexes both upstream and downstream VCs.
- PORT_NUM, 5, number of router ports (port_t values LOCAL, NORTH, SOUTH, WEST, EAST).
- VC_NUM, 2, VCs per port.
- VC_SIZE is taken from noc_params, = clog2(VC_NUM).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- idle_downstream_vc_i  input  VC_TOTAL  bit d=1: downstream VC d has drained and may be freed.
- vc_to_allocate_i  input  VC_TOTAL  bit u=1: upstream VC u requests a downstream VC this cycle.
- out_port_i  input  port_t[VC_TOTAL]  requested output port of each upstream VC.
- vc_new_o  output  VC_SIZE x VC_TOTAL (unpacked)  allocated VC id within the port (d mod VC_NUM), per upstream VC.
- vc_valid_o  output  VC_TOTAL  bit u=1: vc_new_o[u] is a valid allocation this cycle.

Behaviour:
- Downstream VC d belongs to port d/VC_NUM, with local id d mod VC_NUM.
- State:
  - available[VC_TOTAL], reset to all 1.
  - One input-arbiter pointer per upstream VC, log2(VC_TOTAL) bits, reset 0.
  - One output-arbiter pointer per downstream VC, reset 0.
- Reset is asynchronous: asserting rst at any time, including mid-operation, immediately restores the reset state. State holds its reset value while rst=1.
- Outputs are combinational from the current inputs and state, with zero latency: a grant is visible in the same cycle the request is applied. State updates at the next rising clk.
- Request matrix: req[u][d] = vc_to_allocate_i[u] & available[d] & (d/VC_NUM == out_port_i[u]).
- Input stage, per upstream VC u: round-robin scan of req[u][*], starting at ptr_in[u] and wrapping modulo VC_TOTAL. The first set bit gives the single grant g_in[u][d].
- Output stage, per downstream VC d: round-robin scan of g_in[*][d], starting at ptr_out[d] with wrap. The first set bit gives the final grant g_out[u][d].
- For each u with a final grant to d:
  - vc_valid_o[u]=1 and vc_new_o[u]=d mod VC_NUM.
  - Otherwise vc_valid_o[u]=0 and vc_new_o[u] is don't-care, driven X in simulation. Consumers and benches qualify vc_new_o with vc_valid_o.
- Pointer update on clk, only for arbiters that granted: pointer <- (granted index + 1) mod VC_TOTAL.
  - An input pointer advances on its input-stage grant even if the output stage rejects it.
  - Arbiters with no grant keep their pointer.
- Availability update on clk:
  - A d granted this cycle becomes 0.
  - An unavailable d with idle_downstream_vc_i[d]=1 becomes 1.
  - Otherwise d holds its value; an available d stays available regardless of idle.
- The idle input only frees VCs that are currently allocated. A VC freed at edge t is requestable in the cycle after t.
- No request, or all VCs on the requested port unavailable: vc_valid_o[u]=0 and no state change for u.
- Several upstream VCs competing for one port with VC_NUM free VCs:
  - Input arbiters with equal pointers may all pick the same d; only one wins.
  - Allocation is not maximal; losers retry in later cycles.
- Each downstream VC is granted to at most one upstream VC per cycle, and each upstream VC receives at most one downstream VC.

Test Plan:
- Single request: after reset, vc_to_allocate_i=0x001, out_port_i[0]=port 1 (d=2,3), idle=0. Expect vc_valid_o=0x001 and vc_new_o[0]=0 (d=2). Next cycle, same request: vc_new_o[0]=1 (d=3). Third cycle: vc_valid_o=0.
- Re-freeing: continue the previous case with idle_downstream_vc_i[2]=1 for one cycle. The following cycle, the same request gets vc_new_o[0]=0. An idle pulse on a VC that is already available has no effect.
- All-to-one-port: after reset, vc_to_allocate_i=all 1s, all out_port_i=port 0, idle=all 1s. Expect only vc_valid_o[0]=1 with vc_new_o[0]=0. Next cycle: d=0 is unavailable; all upstream VCs pick d=1 and upstream 0 wins again (ptr_out[1]=0).
- Repeat all-to-one-port for each of the 5 ports. vc_valid_o must be one-hot or zero, and no downstream VC may be granted twice while unavailable.
- Random stress: 10+ cycles of random vc_to_allocate_i, idle_downstream_vc_i and out_port_i. Compare per cycle (sampled mid-cycle) against a reference model of the two-stage round-robin and the availability rules.
- Asynchronous reset mid-run: assert rst between edges. Immediately all VCs are available and all pointers are 0, and the next request behaves like the first scenario.

Source files
------------

// File: rtl/vc_allocator.sv
// Separable input-first VC allocator for a 5-port router with round-robin arbiters at both stages.
// Grants are combinational in the request cycle. Arbiter pointers and availability update on the next clk edge.
package noc_params;
  localparam int NOC_VC_NUM = 2;
  localparam int VC_SIZE = $clog2(NOC_VC_NUM);
  typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;
endpackage

module vc_allocator #(
  parameter int VC_TOTAL = 10,
  parameter int PORT_NUM = 5,
  parameter int VC_NUM   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [VC_TOTAL-1:0]           idle_downstream_vc_i,
  input  logic [VC_TOTAL-1:0]           vc_to_allocate_i,
  input  noc_params::port_t             out_port_i [VC_TOTAL],
  output logic [noc_params::VC_SIZE-1:0] vc_new_o  [VC_TOTAL],
  output logic [VC_TOTAL-1:0]           vc_valid_o
);

  localparam int PW = $clog2(VC_TOTAL);
  localparam int VS = noc_params::VC_SIZE;

  logic [VC_TOTAL-1:0] avail;
  logic [PW-1:0]       ptr_in  [VC_TOTAL];
  logic [PW-1:0]       ptr_out [VC_TOTAL];

  logic [VC_TOTAL-1:0] req     [VC_TOTAL];  // [upstream][downstream]
  logic [VC_TOTAL-1:0] col     [VC_TOTAL];  // [downstream][upstream] input-stage grants
  logic [VC_TOTAL-1:0] in_vld;
  logic [PW-1:0]       in_idx  [VC_TOTAL];
  logic [VC_TOTAL-1:0] out_vld;
  logic [PW-1:0]       out_idx [VC_TOTAL];

  // Returns {found, index} of the first set bit at or after ptr, wrapping.
  function automatic logic [PW:0] rr_pick(input logic [VC_TOTAL-1:0] r, input logic [PW-1:0] ptr);
    logic [PW:0] res;
    int idx;
    res = '0;
    for (int i = 0; i < VC_TOTAL; i++) begin
      idx = int'(ptr) + i;
      if (idx >= VC_TOTAL) idx = idx - VC_TOTAL;
      if (!res[PW] && r[idx]) res = {1'b1, PW'(idx)};
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] idx);
    return (idx == PW'(VC_TOTAL - 1)) ? '0 : idx + 1'b1;
  endfunction

  always_comb begin
    for (int u = 0; u < VC_TOTAL; u++) begin
      for (int d = 0; d < VC_TOTAL; d++) begin
        req[u][d] = vc_to_allocate_i[u] & avail[d]
                  & (int'(out_port_i[u]) < PORT_NUM)
                  & ((d / VC_NUM) == int'(out_port_i[u]));
      end
    end
  end

  always_comb begin
    for (int u = 0; u < VC_TOTAL; u++) begin
      {in_vld[u], in_idx[u]} = rr_pick(req[u], ptr_in[u]);
    end
  end

  always_comb begin
    for (int d = 0; d < VC_TOTAL; d++) begin
      for (int u = 0; u < VC_TOTAL; u++) begin
        col[d][u] = in_vld[u] && (in_idx[u] == PW'(d));
      end
      {out_vld[d], out_idx[d]} = rr_pick(col[d], ptr_out[d]);
    end
  end

  always_comb begin
    vc_valid_o = '0;
    for (int u = 0; u < VC_TOTAL; u++) vc_new_o[u] = 'x;
    for (int d = 0; d < VC_TOTAL; d++) begin
      if (out_vld[d]) begin
        vc_valid_o[out_idx[d]] = 1'b1;
        vc_new_o[out_idx[d]]   = VS'(d % VC_NUM);
      end
    end
  end

  // Input pointers advance on their own grant even if the output stage rejected it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avail <= '1;
      for (int i = 0; i < VC_TOTAL; i++) begin
        ptr_in[i]  <= '0;
        ptr_out[i] <= '0;
      end
    end else begin
      for (int i = 0; i < VC_TOTAL; i++) begin
        if (in_vld[i])  ptr_in[i]  <= wrap_inc(in_idx[i]);
        if (out_vld[i]) ptr_out[i] <= wrap_inc(out_idx[i]);
        avail[i] <= out_vld[i] ? 1'b0 : (avail[i] | idle_downstream_vc_i[i]);
      end
    end
  end

endmodule

// File: tb/tb_vc_allocator.sv
// Directed and model-checked bench for vc_allocator; inputs change at posedge+1, outputs sampled at posedge+4.
module tb_vc_allocator;
  import noc_params::*;

  localparam int VT = 10;

  logic               clk;
  logic               rst;
  logic [VT-1:0]      idle;
  logic [VT-1:0]      req;
  port_t              out_port [VT];
  logic [VC_SIZE-1:0] vc_new   [VT];
  logic [VT-1:0]      vc_valid;

  int checks;
  int errors;

  int            m_pin  [VT];
  int            m_pout [VT];
  bit            m_avail[VT];
  int            gi     [VT];
  int            go     [VT];
  logic [VT-1:0] exp_valid;
  int            exp_new[VT];

  vc_allocator #(.VC_TOTAL(VT), .PORT_NUM(5), .VC_NUM(2)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .idle_downstream_vc_i (idle),
    .vc_to_allocate_i     (req),
    .out_port_i           (out_port),
    .vc_new_o             (vc_new),
    .vc_valid_o           (vc_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ports(input port_t p);
    for (int i = 0; i < VT; i++) out_port[i] = p;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    idle = '0;
    set_ports(LOCAL);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < VT; i++) begin
      m_pin[i] = 0;
      m_pout[i] = 0;
      m_avail[i] = 1'b1;
    end
  endtask

  task automatic model_eval();
    int d;
    int u;
    for (int a = 0; a < VT; a++) begin
      gi[a] = -1;
      if (req[a]) begin
        for (int k = 0; k < VT; k++) begin
          d = (m_pin[a] + k) % VT;
          if (gi[a] < 0 && m_avail[d] && (d / 2) == int'(out_port[a])) gi[a] = d;
        end
      end
    end
    exp_valid = '0;
    for (int b = 0; b < VT; b++) begin
      go[b] = -1;
      for (int k = 0; k < VT; k++) begin
        u = (m_pout[b] + k) % VT;
        if (go[b] < 0 && gi[u] == b) go[b] = u;
      end
      if (go[b] >= 0) begin
        exp_valid[go[b]] = 1'b1;
        exp_new[go[b]] = b % 2;
      end
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < VT; i++) begin
      if (gi[i] >= 0) m_pin[i] = (gi[i] + 1) % VT;
      if (go[i] >= 0) begin
        m_pout[i] = (go[i] + 1) % VT;
        m_avail[i] = 1'b0;
      end else if (!m_avail[i] && idle[i]) begin
        m_avail[i] = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    #3;
    checks++;
    if (vc_valid !== 10'h000) begin
      errors++;
      $display("FAIL reset_valid: got %h expected %h", vc_valid, 10'h000);
    end
  endtask

  task automatic test_single();
    req = 10'h001;
    out_port[0] = NORTH;
    #3;
    checks++;
    if (vc_valid !== 10'h001 || vc_new[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_c1: valid=%h new0=%b expected valid=001 new0=0", vc_valid, vc_new[0]);
    end
    tick();
    #3;
    checks++;
    if (vc_valid !== 10'h001 || vc_new[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_c2: valid=%h new0=%b expected valid=001 new0=1", vc_valid, vc_new[0]);
    end
    tick();
    #3;
    checks++;
    if (vc_valid !== 10'h000) begin
      errors++;
      $display("FAIL single_c3_exhausted: valid=%h expected 000", vc_valid);
    end
  endtask

  task automatic test_refree();
    tick();
    idle = 10'h004;
    #3;
    checks++;
    if (vc_valid !== 10'h000) begin
      errors++;
      $display("FAIL refree_idle_cycle: valid=%h expected 000", vc_valid);
    end
    tick();
    idle = '0;
    #3;
    checks++;
    if (vc_valid !== 10'h001 || vc_new[0] !== 1'b0) begin
      errors++;
      $display("FAIL refree_regrant: valid=%h new0=%b expected valid=001 new0=0", vc_valid, vc_new[0]);
    end
    // Idle on an already-available VC must not disturb it.
    tick();
    req = '0;
    idle = 10'h001;
    #3;
    checks++;
    if (vc_valid !== 10'h000) begin
      errors++;
      $display("FAIL refree_noreq: valid=%h expected 000", vc_valid);
    end
    tick();
    idle = '0;
    req = 10'h001;
    out_port[0] = LOCAL;
    #3;
    checks++;
    if (vc_valid !== 10'h001 || vc_new[0] !== 1'b0) begin
      errors++;
      $display("FAIL idle_avail_d0: valid=%h new0=%b expected valid=001 new0=0", vc_valid, vc_new[0]);
    end
    tick();
    #3;
    checks++;
    if (vc_valid !== 10'h001 || vc_new[0] !== 1'b1) begin
      errors++;
      $display("FAIL idle_avail_d1: valid=%h new0=%b expected valid=001 new0=1", vc_valid, vc_new[0]);
    end
    tick();
    #3;
    checks++;
    if (vc_valid !== 10'h000) begin
      errors++;
      $display("FAIL idle_avail_done: valid=%h expected 000", vc_valid);
    end
  endtask

  task automatic test_all_to_local();
    do_reset();
    req = '1;
    idle = '1;
    set_ports(LOCAL);
    #3;
    checks++;
    if (vc_valid !== 10'h001 || vc_new[0] !== 1'b0) begin
      errors++;
      $display("FAIL all_local_c1: valid=%h new0=%b expected valid=001 new0=0", vc_valid, vc_new[0]);
    end
    tick();
    #3;
    checks++;
    if (vc_valid !== 10'h001 || vc_new[0] !== 1'b1) begin
      errors++;
      $display("FAIL all_local_c2: valid=%h new0=%b expected valid=001 new0=1", vc_valid, vc_new[0]);
    end
    // d0 was freed by idle; its output pointer now favours upstream 1.
    tick();
    #3;
    checks++;
    if (vc_valid !== 10'h002 || vc_new[1] !== 1'b0) begin
      errors++;
      $display("FAIL all_local_c3: valid=%h new1=%b expected valid=002 new1=0", vc_valid, vc_new[1]);
    end
  endtask

  task automatic test_each_port();
    for (int p = 0; p < 5; p++) begin
      do_reset();
      req = '1;
      set_ports(port_t'(p));
      #3;
      checks++;
      if (vc_valid !== 10'h001 || vc_new[0] !== 1'b0) begin
        errors++;
        $display("FAIL port%0d_c1: valid=%h new0=%b expected valid=001 new0=0", p, vc_valid, vc_new[0]);
      end
      tick();
      #3;
      checks++;
      if (vc_valid !== 10'h001 || vc_new[0] !== 1'b1) begin
        errors++;
        $display("FAIL port%0d_c2: valid=%h new0=%b expected valid=001 new0=1", p, vc_valid, vc_new[0]);
      end
      tick();
      #3;
      checks++;
      if (vc_valid !== 10'h000) begin
        errors++;
        $display("FAIL port%0d_c3_no_regrant: valid=%h expected 000", p, vc_valid);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    model_reset();
    for (int c = 0; c < 40; c++) begin
      req  = 10'($urandom);
      idle = 10'($urandom) & 10'($urandom);
      for (int i = 0; i < VT; i++) out_port[i] = port_t'($urandom_range(0, 4));
      #1;
      model_eval();
      #2;
      checks++;
      if (vc_valid !== exp_valid) begin
        errors++;
        $display("FAIL rand_valid cycle %0d: got %h expected %h", c, vc_valid, exp_valid);
      end
      for (int u = 0; u < VT; u++) begin
        if (exp_valid[u] && vc_valid[u]) begin
          checks++;
          if (vc_new[u] !== VC_SIZE'(exp_new[u])) begin
            errors++;
            $display("FAIL rand_new cycle %0d u%0d: got %b expected %0d", c, u, vc_new[u], exp_new[u]);
          end
        end
      end
      tick();
      model_update();
    end
  endtask

  task automatic test_async_reset();
    req = 10'h001;
    idle = '0;
    set_ports(NORTH);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (vc_valid !== 10'h001 || vc_new[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_rst_immediate: valid=%h new0=%b expected valid=001 new0=0", vc_valid, vc_new[0]);
    end
    rst = 1'b0;
    tick();
    #3;
    checks++;
    if (vc_valid !== 10'h001 || vc_new[0] !== 1'b1) begin
      errors++;
      $display("FAIL async_rst_c2: valid=%h new0=%b expected valid=001 new0=1", vc_valid, vc_new[0]);
    end
    tick();
    #3;
    checks++;
    if (vc_valid !== 10'h000) begin
      errors++;
      $display("FAIL async_rst_c3: valid=%h expected 000", vc_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst  = 1'b1;
    req  = '0;
    idle = '0;
    set_ports(LOCAL);
    test_reset();
    test_single();
    test_refree();
    test_all_to_local();
    test_each_port();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
